// File: rtl/lane_game_engine.sv
// Lane-crossing game core: rotating obstacle lanes, edge-detected
// buttons, collision/win detection, lives, score and game-state FSM.
module lane_game_engine #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int TICK_DIV = 100000000,
  parameter logic [ROWS*COLS-1:0] LANE_INIT = '0,
  parameter logic [ROWS-1:0] LANE_MASK = 8'b0110_1110,
  parameter logic [ROWS-1:0] LANE_DIR = 8'b0010_1010,
  parameter int START_COL = 4,
  parameter int LIVES = 3,
  parameter int HOLD_TICKS = 2,
  localparam int RW = $clog2(ROWS),
  localparam int LW = $clog2(LIVES + 1),
  localparam int CW = $clog2(TICK_DIV),
  localparam int HW = $clog2(HOLD_TICKS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 up,
  input  logic                 down,
  input  logic                 left,
  input  logic                 right,
  output logic [ROWS*COLS-1:0] lanes,
  output logic [RW-1:0]        frog_row,
  output logic [COLS-1:0]      frog_col,
  output logic [LW-1:0]        lives,
  output logic [7:0]           score,
  output logic                 dead,
  output logic                 win,
  output logic                 game_over,
  output logic                 tick
);

  typedef enum logic [1:0] {
    PLAY, HIT, WIN, OVER
  } state_t;

  localparam logic [RW-1:0] ROW_START = RW'(ROWS - 1);
  localparam logic [COLS-1:0] COL_START =
    COLS'(1) << START_COL;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [COLS-1:0] col_q, col_d;
  logic [LW-1:0]   lives_q, lives_d;
  logic [7:0]      score_q, score_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      btn_q;
  logic [3:0]      btn;
  logic [3:0]      press;
  logic            hit_now;
  logic [COLS-1:0] lane_q [ROWS];

  assign tick  = (cnt_q == CW'(TICK_DIV - 1));
  assign btn   = {up, down, left, right};
  assign press = btn_q & ~btn;
  assign hit_now = LANE_MASK[row_q] &&
                   (|(lane_q[row_q] & col_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      btn_q <= '1;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
      btn_q <= btn;
    end
  end

  // Road rows step once per tick; other rows stay at their init pattern.
  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (reset) begin
        lane_q[r] <= LANE_INIT[r*COLS +: COLS];
      end else if (tick && state_q != OVER && LANE_MASK[r]) begin
        if (LANE_DIR[r])
          lane_q[r] <= {lane_q[r][0], lane_q[r][COLS-1:1]};
        else
          lane_q[r] <= {lane_q[r][COLS-2:0], lane_q[r][COLS-1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PLAY;
      row_q   <= ROW_START;
      col_q   <= COL_START;
      lives_q <= LW'(LIVES);
      score_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lives_q <= lives_d;
      score_q <= score_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lives_d = lives_q;
    score_d = score_q;
    hold_d  = hold_q;
    unique case (state_q)
      PLAY: begin
        if (hit_now) begin
          state_d = HIT;
          hold_d  = '0;
          if (lives_q != '0) lives_d = lives_q - LW'(1);
        end else if (row_q == '0) begin
          state_d = WIN;
          hold_d  = '0;
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
        end else begin
          priority case (1'b1)
            press[3]:
              if (row_q != '0) row_d = row_q - RW'(1);
            press[2]:
              if (row_q != ROW_START) row_d = row_q + RW'(1);
            press[1]:
              if (!col_q[COLS-1]) col_d = col_q << 1;
            press[0]:
              if (!col_q[0]) col_d = col_q >> 1;
            default: ;
          endcase
        end
      end
      HIT, WIN: begin
        if (tick) begin
          if (hold_q == HW'(HOLD_TICKS - 1)) begin
            if (state_q == HIT && lives_q == '0) begin
              state_d = OVER;
            end else begin
              state_d = PLAY;
              row_d   = ROW_START;
              col_d   = COL_START;
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      OVER: ;
      default: ;
    endcase
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_pack
    assign lanes[r*COLS +: COLS] = lane_q[r];
  end

  assign frog_row  = row_q;
  assign frog_col  = col_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign dead      = (state_q == HIT) || (state_q == OVER);
  assign win       = (state_q == WIN);
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_lane_game_engine.sv
// Directed bench for lane_game_engine: hits/over on an all-road
// field, lane rotation, and movement/win/score on a safe field.
module tb_lane_game_engine;

  localparam logic [63:0] LANE_A = 64'hFFFF_C0FF_FFFF_FFFF;
  localparam logic [63:0] LANE_B = 64'h0000_00A5_0081_8800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic hi = 1'b1;
  logic ua, da, la, ra;
  logic uc, dc, lc, rc;

  logic [63:0] lanes_a, lanes_b, lanes_c;
  logic [2:0]  row_a, row_b, row_c;
  logic [7:0]  col_a, col_b, col_c;
  logic [1:0]  lives_a, lives_b, lives_c;
  logic [7:0]  score_a, score_b, score_c;
  logic dead_a, win_a, over_a, tick_a;
  logic dead_b, win_b, over_b, tick_b;
  logic dead_c, win_c, over_c, tick_c;

  int errors = 0;
  int checks = 0;

  lane_game_engine #(
    .TICK_DIV(4), .LANE_INIT(LANE_A), .HOLD_TICKS(2)
  ) dut_a (
    .clk(clk), .reset(reset),
    .up(ua), .down(da), .left(la), .right(ra),
    .lanes(lanes_a), .frog_row(row_a), .frog_col(col_a),
    .lives(lives_a), .score(score_a), .dead(dead_a),
    .win(win_a), .game_over(over_a), .tick(tick_a)
  );

  lane_game_engine #(
    .TICK_DIV(4), .LANE_INIT(LANE_B), .HOLD_TICKS(2)
  ) dut_b (
    .clk(clk), .reset(reset),
    .up(hi), .down(hi), .left(hi), .right(hi),
    .lanes(lanes_b), .frog_row(row_b), .frog_col(col_b),
    .lives(lives_b), .score(score_b), .dead(dead_b),
    .win(win_b), .game_over(over_b), .tick(tick_b)
  );

  lane_game_engine #(
    .TICK_DIV(4), .LANE_INIT(64'h0), .HOLD_TICKS(2)
  ) dut_c (
    .clk(clk), .reset(reset),
    .up(uc), .down(dc), .left(lc), .right(rc),
    .lanes(lanes_c), .frog_row(row_c), .frog_col(col_c),
    .lives(lives_c), .score(score_c), .dead(dead_c),
    .win(win_c), .game_over(over_c), .tick(tick_c)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {ua, da, la, ra} = 4'hF;
    {uc, dc, lc, rc} = 4'hF;
    step(2);
    reset = 1'b0;
  endtask

  task automatic press_up_c();
    uc = 1'b0;
    step(1);
    uc = 1'b1;
    step(1);
  endtask

  task automatic wait_win_end();
    for (int i = 0; i < 20 && win_c; i++) step(1);
    chk("win_exit", win_c, 1'b0);
  endtask

  task automatic win_once();
    for (int i = 0; i < 7; i++) press_up_c();
    wait_win_end();
  endtask

  initial begin
    // all-road field: reset, three hits, game over, reset recovery
    do_reset();
    chk("a_rst_lanes", lanes_a, LANE_A);
    chk("a_rst_row", row_a, 3'd7);
    chk("a_rst_col", col_a, 8'h10);
    chk("a_rst_lives", lives_a, 2'd3);
    chk("a_rst_score", score_a, 8'd0);
    chk("a_rst_flags", {dead_a, win_a, over_a, tick_a}, 4'b0);
    ua = 1'b0;
    step(1);
    chk("a_move_row6", row_a, 3'd6);
    chk("a_no_dead_yet", dead_a, 1'b0);
    step(1);
    chk("a_hit1_dead", dead_a, 1'b1);
    chk("a_hit1_lives", lives_a, 2'd2);
    ua = 1'b1;
    step(5);
    chk("a_hold_dead", dead_a, 1'b1);
    step(1);
    chk("a_resp_dead", dead_a, 1'b0);
    chk("a_resp_row", row_a, 3'd7);
    chk("a_resp_col", col_a, 8'h10);
    ua = 1'b0;
    step(2);
    chk("a_hit2_lives", lives_a, 2'd1);
    ua = 1'b1;
    step(6);
    chk("a_resp2_row", row_a, 3'd7);
    ua = 1'b0;
    step(2);
    chk("a_hit3_lives", lives_a, 2'd0);
    chk("a_hit3_over", over_a, 1'b0);
    ua = 1'b1;
    step(6);
    chk("a_over", over_a, 1'b1);
    chk("a_over_dead", dead_a, 1'b1);
    chk("a_over_row", row_a, 3'd6);
    chk("a_row5_at_over", lanes_a[47:40], 8'h03);
    da = 1'b0;
    step(1);
    chk("a_over_press", row_a, 3'd6);
    da = 1'b1;
    step(2);
    chk("a_over_tick", tick_a, 1'b1);
    step(5);
    chk("a_row5_frozen", lanes_a[47:40], 8'h03);
    reset = 1'b1;
    step(1);
    chk("a_rov_lanes", lanes_a, LANE_A);
    chk("a_rov_row", row_a, 3'd7);
    chk("a_rov_lives", lives_a, 2'd3);
    chk("a_rov_flags", {dead_a, over_a, tick_a}, 3'b0);
    reset = 1'b0;
    ua = 1'b0;
    step(1);
    chk("a_post_rov_move", row_a, 3'd6);
    ua = 1'b1;
    step(1);
    chk("a_hit_again", dead_a, 1'b1);
    reset = 1'b1;
    step(1);
    chk("a_rhit_dead", dead_a, 1'b0);
    chk("a_rhit_lives", lives_a, 2'd3);
    chk("a_rhit_row", row_a, 3'd7);
    chk("a_rhit_col", col_a, 8'h10);
    reset = 1'b0;
    ua = 1'b0;
    step(1);
    chk("a_post_rhit_move", row_a, 3'd6);
    ua = 1'b1;

    // rotation field
    do_reset();
    step(2);
    chk("b_tick_t2", tick_b, 1'b0);
    step(1);
    chk("b_tick_t3", tick_b, 1'b1);
    chk("b_row1_pre", lanes_b[15:8], 8'h88);
    step(1);
    chk("b_tick_t4", tick_b, 1'b0);
    chk("b_lanes_1", lanes_b, 64'h0000_00A5_0003_4400);
    step(4);
    chk("b_lanes_2", lanes_b, 64'h0000_00A5_0006_2200);

    // safe field: edge-detected moves, clamps, wins, score saturation
    do_reset();
    uc = 1'b0;
    step(20);
    chk("c_hold_up", row_c, 3'd6);
    uc = 1'b1;
    step(1);
    uc = 1'b0;
    step(1);
    chk("c_second_up", row_c, 3'd5);
    uc = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      rc = 1'b0;
      step(1);
      rc = 1'b1;
      step(1);
    end
    chk("c_right_lsb", col_c, 8'h01);
    rc = 1'b0;
    step(1);
    rc = 1'b1;
    step(1);
    chk("c_right_clamp", col_c, 8'h01);
    uc = 1'b0;
    rc = 1'b0;
    step(1);
    chk("c_up_priority_row", row_c, 3'd4);
    chk("c_up_priority_col", col_c, 8'h01);
    uc = 1'b1;
    rc = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) press_up_c();
    chk("c_win", win_c, 1'b1);
    chk("c_win_score", score_c, 8'd1);
    chk("c_win_row", row_c, 3'd0);
    wait_win_end();
    chk("c_resp_row", row_c, 3'd7);
    chk("c_resp_col", col_c, 8'h10);
    chk("c_resp_lives", lives_c, 2'd3);
    chk("c_resp_score", score_c, 8'd1);
    for (int k = 0; k < 254; k++) win_once();
    chk("c_score_255", score_c, 8'd255);
    for (int i = 0; i < 7; i++) press_up_c();
    chk("c_win_256", win_c, 1'b1);
    chk("c_score_sat", score_c, 8'd255);
    wait_win_end();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
